maxpool_ctrl: RTL and testbench
===============================

# maxpool_ctrl

Sequencing controller for the max-pool stage. It streams a stored IN_SIZE×IN_SIZE feature map out of the feature-map buffer one element per cycle, window by window. It reduces each POOL×POOL window to its signed maximum and writes the OUT_SIZE×OUT_SIZE result into the pooled-map buffer. It sits between the convolution output buffer and the dense-layer input buffer, and is started by the top-level inference sequencer through a start/done handshake.

## Interface
- IN_SIZE, 26: input map height and width (elements).
- OUT_SIZE, 2: output map height and width; POOL = IN_SIZE/OUT_SIZE = 13.
- ELEMENT_SIZE, 20: element width, signed two's complement.
- RD_ADDR_W, 10: read address width, ≥ clog2(IN_SIZE²).
- WR_ADDR_W, 2: write address width, ≥ clog2(OUT_SIZE²).
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  reset; synchronous, active-low.
- start  in  1  begin a pooling pass; sampled only in IDLE.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at pass completion.
- rd_en  out  1  buffer read strobe.
- rd_addr  out  RD_ADDR_W  element address, row-major (row*IN_SIZE+col).
- rd_data  in  ELEMENT_SIZE  read data, valid exactly one cycle after rd_en.
- wr_en  out  1  pooled-buffer write strobe.
- wr_addr  out  WR_ADDR_W  output index wy*OUT_SIZE+wx.
- wr_data  out  ELEMENT_SIZE  window maximum.

## Operation
- States:
  - IDLE: if start=1, go to READ; else stay in IDLE.
  - READ: lasts POOL² cycles per window, then go to LAST.
  - LAST: 1 cycle, then go to WRITE.
  - WRITE: 1 cycle, then go to READ for the next window, or to DONE after the last window.
  - DONE: 1 cycle, then go to IDLE.
- Windows are visited row-major: (wy,wx) = (0,0),(0,1),…,(OUT_SIZE-1,OUT_SIZE-1).
- Inside a window, (r,c) is visited row-major.
- In READ: rd_en=1 and rd_addr=(wy*POOL+r)*IN_SIZE + wx*POOL + c.
- Accumulator:
  - On the first data beat of a window, load rd_data unconditionally. There is no zero or minimum pre-initialisation.
  - On each later beat, load rd_data if it is signed-greater than the accumulator.
  - Ties keep the held value.
- The last beat of a window arrives in LAST.
- In WRITE: wr_en=1, wr_addr=wy*OUT_SIZE+wx, wr_data=accumulator.
- Outside WRITE, wr_en=0 and wr_data holds its last value. rd_en=0 outside READ.
- start while busy=1 is ignored. No queuing.
- If start is still high in IDLE after DONE, a new pass begins.
- IN_SIZE not divisible by OUT_SIZE is an elaboration error.

## Timing
- Reset (rst=0 at an edge) gives: state IDLE, busy=0, done=0, rd_en=0, wr_en=0, rd_addr=0, wr_addr=0, wr_data=0, accumulator=0.
- Reset mid-pass: the pass is abandoned, no further writes occur, and outputs are at reset values the cycle after the edge.
- Start sampled at edge 0 → first READ cycle is cycle 1.
- Each window takes POOL²+2 = 171 cycles.
- Write n (n=0..3) occurs in cycle 171n+171. done=1 in cycle 685, IDLE in cycle 686.
- Read latency is fixed at 1 cycle. rd_data is ignored in cycles where no read was issued the previous cycle.

## Structure
- Package maxpool_pkg:
  - state enum (IDLE, READ, LAST, WRITE, DONE);
  - localparams POOL and POOL_SQ;
  - an address-width helper.
- Sub-module maxpool_acc: signed compare-and-hold register with ports load_first, load, din and q.
- Counters live in maxpool_ctrl: r, c (0..POOL-1), wx, wy (0..OUT_SIZE-1).

## Test plan
- Bench uses a memory model returning rd_data one cycle after rd_en.
- Ramp (element value = its address) → writes 324, 337, 662, 675 to addresses 0..3. done pulses in cycle 685 only.
- All elements -5, except -1 at (row 3, col 20) → outputs -5, -1, -5, -5. Checks signed compare and the no-zero-init rule.
- 1000 at address 0, all else 0 → output[0]=1000 (first-beat load). Outputs 1..3 = 0.
- Extremes: 20'h80000 everywhere, with 20'h7FFFF at address 675 → output[3]=524287. Others = -524288.
- start pulsed again at cycles 5 and 400 → ignored, exactly 4 writes. start held high through DONE → second pass starts at cycle 687 with identical results.
- rst=0 for one cycle at cycle 300 → from cycle 301 busy=0, rd_en=0, no writes. A fresh start produces correct ramp results.

Source files
------------

// File: rtl/maxpool_pkg.sv
// maxpool_pkg: shared types and constants for the max-pool controller.
// Holds the state encoding, default geometry and a width helper.
package maxpool_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    LAST,
    WRITE,
    DONE
  } state_t;

  localparam int IN_SIZE_D  = 26;
  localparam int OUT_SIZE_D = 2;
  localparam int POOL       = IN_SIZE_D / OUT_SIZE_D;
  localparam int POOL_SQ    = POOL * POOL;

  // Bits needed to index n items (at least one bit).
  function automatic int addr_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/maxpool_acc.sv
// maxpool_acc: signed compare-and-hold register for one pooling window.
// Ports: load_first forces a load, load keeps the signed max; din in, q out.
module maxpool_acc #(
  parameter int W = 20
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_first,
  input  logic         load,
  input  logic [W-1:0] din,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      q <= '0;
    end else if (load_first) begin
      q <= din;
    end else if (load && ($signed(din) > $signed(q))) begin
      q <= din;
    end
  end

endmodule

// File: rtl/maxpool_ctrl.sv
// maxpool_ctrl: streams the feature map window by window and writes maxima.
// Ports: start/busy/done handshake, rd_en/rd_addr/rd_data, wr_en/wr_addr/wr_data.
module maxpool_ctrl
  import maxpool_pkg::*;
#(
  parameter int IN_SIZE      = IN_SIZE_D,
  parameter int OUT_SIZE     = OUT_SIZE_D,
  parameter int ELEMENT_SIZE = 20,
  parameter int RD_ADDR_W    = 10,
  parameter int WR_ADDR_W    = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    rd_en,
  output logic [RD_ADDR_W-1:0]    rd_addr,
  input  logic [ELEMENT_SIZE-1:0] rd_data,
  output logic                    wr_en,
  output logic [WR_ADDR_W-1:0]    wr_addr,
  output logic [ELEMENT_SIZE-1:0] wr_data
);

  localparam int PW = IN_SIZE / OUT_SIZE;
  localparam int CW = addr_w(PW);
  localparam int OW = addr_w(OUT_SIZE);
  localparam logic [CW-1:0] CMAX = CW'(PW - 1);
  localparam logic [OW-1:0] OMAX = OW'(OUT_SIZE - 1);

  if (IN_SIZE % OUT_SIZE != 0) begin : g_bad_div
    $error("IN_SIZE must be a multiple of OUT_SIZE");
  end
  if (RD_ADDR_W < addr_w(IN_SIZE * IN_SIZE)) begin : g_bad_rd
    $error("RD_ADDR_W too narrow");
  end
  if (WR_ADDR_W < addr_w(OUT_SIZE * OUT_SIZE)) begin : g_bad_wr
    $error("WR_ADDR_W too narrow");
  end

  state_t                  state;
  logic [CW-1:0]           r;
  logic [CW-1:0]           c;
  logic [OW-1:0]           wx;
  logic [OW-1:0]           wy;
  logic                    beat;
  logic                    first;
  logic [ELEMENT_SIZE-1:0] acc_q;
  logic [ELEMENT_SIZE-1:0] hold_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      r      <= '0;
      c      <= '0;
      wx     <= '0;
      wy     <= '0;
      beat   <= 1'b0;
      first  <= 1'b0;
      hold_q <= '0;
    end else begin
      // Data for a read lands one cycle later; track it here.
      beat  <= (state == READ);
      first <= (state == READ) && (r == '0) && (c == '0);
      unique case (state)
        IDLE: begin
          if (start) begin
            state <= READ;
            r     <= '0;
            c     <= '0;
            wx    <= '0;
            wy    <= '0;
          end
        end
        READ: begin
          if (c == CMAX) begin
            c <= '0;
            if (r == CMAX) begin
              r     <= '0;
              state <= LAST;
            end else begin
              r <= r + 1'b1;
            end
          end else begin
            c <= c + 1'b1;
          end
        end
        LAST: state <= WRITE;
        WRITE: begin
          hold_q <= acc_q;
          if (wx == OMAX) begin
            wx <= '0;
            if (wy == OMAX) begin
              wy    <= '0;
              state <= DONE;
            end else begin
              wy    <= wy + 1'b1;
              state <= READ;
            end
          end else begin
            wx    <= wx + 1'b1;
            state <= READ;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  maxpool_acc #(
    .W(ELEMENT_SIZE)
  ) u_acc (
    .clk       (clk),
    .rst       (rst),
    .load_first(first),
    .load      (beat & ~first),
    .din       (rd_data),
    .q         (acc_q)
  );

  assign busy  = (state != IDLE);
  assign done  = (state == DONE);
  assign rd_en = (state == READ);
  assign wr_en = (state == WRITE);

  assign rd_addr = RD_ADDR_W'((int'(wy) * PW + int'(r)) * IN_SIZE
                   + int'(wx) * PW + int'(c));
  assign wr_addr = WR_ADDR_W'(int'(wy) * OUT_SIZE + int'(wx));

  // Acc is stable through WRITE; hold_q keeps the value afterwards.
  assign wr_data = wr_en ? acc_q : hold_q;

endmodule

// File: tb/tb_maxpool_ctrl.sv
// tb_maxpool_ctrl: directed bench for maxpool_ctrl with a 1-cycle memory.
// Table-driven passes plus start-pulse, held-start and mid-pass reset cases.
module tb_maxpool_ctrl;
  import maxpool_pkg::*;

  localparam int E   = 20;
  localparam int WIN = POOL_SQ + 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          busy;
  logic          done;
  logic          rd_en;
  logic [9:0]    rd_addr;
  logic [E-1:0]  rd_data;
  logic          wr_en;
  logic [1:0]    wr_addr;
  logic [E-1:0]  wr_data;

  logic [E-1:0]  mem [0:1023];

  int tests = 0;
  int fails = 0;

  int wa [0:15];
  int wd [0:15];
  int wc [0:15];
  int nw;
  int dc [0:3];
  int nd;
  int nrd;
  int b1, ra1, ra_last, wd172, we172;
  int busy_r, rden_r;

  typedef struct {
    string nm;
    int    pat;
    int    e [4];
  } vec_t;

  vec_t tv [4];

  maxpool_ctrl dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .busy   (busy),
    .done   (done),
    .rd_en  (rd_en),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .wr_en  (wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  // Memory returns data one cycle after rd_en; junk otherwise.
  always @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
    else       rd_data <= E'($urandom);
  end

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic fill(input int pat);
    for (int a = 0; a < 676; a++) begin
      case (pat)
        0:       mem[a] = E'(a);
        1:       mem[a] = (a == 3 * 26 + 20) ? E'(-1) : E'(-5);
        2:       mem[a] = (a == 0) ? E'(1000) : E'(0);
        default: mem[a] = (a == 675) ? 20'h7FFFF : 20'h80000;
      endcase
    end
  endtask

  task automatic set_vec(input int i, input string nm, input int pat,
                         input int e0, input int e1,
                         input int e2, input int e3);
    tv[i].nm   = nm;
    tv[i].pat  = pat;
    tv[i].e[0] = e0;
    tv[i].e[1] = e1;
    tv[i].e[2] = e2;
    tv[i].e[3] = e3;
  endtask

  // Start at edge 0, then sample cycles 1..ncyc on the falling edge.
  task automatic run_pass(input int ncyc, input int hold_until,
                          input int p1, input int p2, input int rst_at);
    nw  = 0;
    nd  = 0;
    nrd = 0;
    @(negedge clk);
    start = 1'b1;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      if (wr_en && nw < 16) begin
        wa[nw] = int'(wr_addr);
        wd[nw] = int'($signed(wr_data));
        wc[nw] = k;
        nw++;
      end
      if (done && nd < 4) begin
        dc[nd] = k;
        nd++;
      end
      if (rd_en) nrd++;
      if (k == 1) begin
        b1  = int'(busy);
        ra1 = int'(rd_addr);
      end
      if (k == POOL_SQ) ra_last = int'(rd_addr);
      if (k == WIN + 1) begin
        wd172 = int'($signed(wr_data));
        we172 = int'(wr_en);
      end
      if (k == rst_at + 1) begin
        busy_r = int'(busy);
        rden_r = int'(rd_en);
      end
      rst   = (k == rst_at) ? 1'b0 : 1'b1;
      start = (k < hold_until) || (k == p1) || (k == p2);
    end
    start = 1'b0;
  endtask

  task automatic check_pass(input string nm, input int e0, input int e1,
                            input int e2, input int e3);
    int ex [4];
    ex[0] = e0;
    ex[1] = e1;
    ex[2] = e2;
    ex[3] = e3;
    chk({nm, " writes"}, nw, 4);
    for (int i = 0; i < 4 && i < nw; i++) begin
      chk($sformatf("%s wr%0d addr", nm, i), wa[i], i);
      chk($sformatf("%s wr%0d data", nm, i), wd[i], ex[i]);
      chk($sformatf("%s wr%0d cycle", nm, i), wc[i], WIN * (i + 1));
    end
    chk({nm, " done count"}, nd, 1);
    chk({nm, " done cycle"}, dc[0], 4 * WIN + 1);
    chk({nm, " read count"}, nrd, 4 * POOL_SQ);
  endtask

  initial begin
    rst   = 1'b0;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset rd_en", int'(rd_en), 0);
    chk("reset wr_en", int'(wr_en), 0);
    chk("reset rd_addr", int'(rd_addr), 0);
    chk("reset wr_addr", int'(wr_addr), 0);
    chk("reset wr_data", int'(wr_data), 0);
    rst = 1'b1;
    @(negedge clk);

    set_vec(0, "ramp", 0, 324, 337, 662, 675);
    set_vec(1, "neg", 1, -5, -1, -5, -5);
    set_vec(2, "first", 2, 1000, 0, 0, 0);
    set_vec(3, "extreme", 3, -524288, -524288, -524288, 524287);

    for (int v = 0; v < 4; v++) begin
      fill(tv[v].pat);
      run_pass(700, 0, -1, -1, -10);
      check_pass(tv[v].nm, tv[v].e[0], tv[v].e[1], tv[v].e[2], tv[v].e[3]);
      if (tv[v].pat == 0) begin
        chk("busy cycle1", b1, 1);
        chk("rd_addr cycle1", ra1, 0);
        chk("rd_addr last beat", ra_last, (POOL - 1) * 26 + POOL - 1);
        chk("wr_en after write", we172, 0);
        chk("wr_data hold", wd172, 324);
      end
    end

    // Starts while busy are ignored.
    fill(0);
    run_pass(700, 0, 5, 400, -10);
    check_pass("pulses", 324, 337, 662, 675);

    // Start held through DONE re-arms at once.
    fill(1);
    run_pass(1380, 1000, -1, -1, -10);
    chk("hold writes", nw, 8);
    for (int i = 0; i < 8 && i < nw; i++) begin
      chk($sformatf("hold wr%0d cycle", i), wc[i],
          (i < 4) ? WIN * (i + 1) : 4 * WIN + 2 + WIN * (i - 3));
      chk($sformatf("hold wr%0d data", i), wd[i], (i % 4 == 1) ? -1 : -5);
    end
    chk("hold done count", nd, 2);
    chk("hold done2 cycle", dc[1], 8 * WIN + 3);

    // Reset mid-pass abandons it.
    fill(0);
    run_pass(700, 0, -1, -1, 300);
    chk("rst writes", nw, 1);
    chk("rst done count", nd, 0);
    chk("rst busy", busy_r, 0);
    chk("rst rd_en", rden_r, 0);
    run_pass(700, 0, -1, -1, -10);
    check_pass("after rst", 324, 337, 662, 675);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
